// File: rtl/dbg_pkg.sv
// Shared definitions for the debug command controller: command and status
// codes, the controller state encoding and frame-decoding helpers.
package dbg_pkg;

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_READ   = 8'h01;
    localparam logic [7:0] CMD_WRITE  = 8'h02;
    localparam logic [7:0] CMD_HALT   = 8'h03;
    localparam logic [7:0] CMD_RESUME = 8'h04;
    localparam logic [7:0] CMD_RESET  = 8'h05;

    localparam logic [7:0] ST_ACK     = 8'hAC;
    localparam logic [7:0] ST_TIMEOUT = 8'hEF;
    localparam logic [7:0] ST_ERR     = 8'hEE;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RX_ADDR   = 3'd1,
        RX_DATA   = 3'd2,
        WAIT_RDY  = 3'd3,
        ISSUE     = 3'd4,
        RELEASE   = 3'd5,
        TX_STATUS = 3'd6,
        TX_DATA   = 3'd7
    } dbg_state_e;

    // Commands followed by address bytes in the host frame.
    function automatic logic has_addr(input logic [7:0] cmd);
        return (cmd == CMD_READ) || (cmd == CMD_WRITE);
    endfunction

    // Commands followed by data bytes in the host frame.
    function automatic logic has_data(input logic [7:0] cmd);
        return (cmd == CMD_WRITE);
    endfunction

    // Codes that are forwarded to the DUT (NOP is handled separately).
    function automatic logic is_known(input logic [7:0] cmd);
        return (cmd >= CMD_READ) && (cmd <= CMD_RESET);
    endfunction

endpackage

// File: rtl/dbg_intf.sv
// Debug bus between the command controller and the device under debug.
interface dbg_intf #(
    parameter int BITSIZE = 32
) ();
    logic [7:0]         cmd;
    logic [BITSIZE-1:0] addr;
    logic [BITSIZE-1:0] data_dbg_dut;
    logic [BITSIZE-1:0] data_dut_dbg;
    logic               dut_ready;
    logic               dut_done;

    modport dbg (
        output cmd, addr, data_dbg_dut,
        input  data_dut_dbg, dut_ready, dut_done
    );

    modport dut (
        input  cmd, addr, data_dbg_dut,
        output data_dut_dbg, dut_ready, dut_done
    );
endinterface

// File: rtl/dbg_cmd_ctrl.sv
// Host-side debug command controller: assembles byte-serial host frames into
// debug bus commands, waits for completion and returns a status byte plus
// read data to the UART transmitter.
module dbg_cmd_ctrl
    import dbg_pkg::*;
#(
    parameter int BITSIZE = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       rstn_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       overflow_o,
    dbg_intf.dbg       dbg
);

    localparam int NBYTES = BITSIZE / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int TMO_W  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NBYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);

    dbg_state_e         state_r;
    logic [7:0]         code_r;
    logic [7:0]         status_r;
    logic [BITSIZE-1:0] opr_r;      // operand assembly on rx, read data on tx
    logic [CNT_W-1:0]   cnt_r;
    logic [TMO_W-1:0]   tmo_r;
    logic [BITSIZE-1:0] opr_next_s;

    assign opr_next_s = (opr_r << 8) | BITSIZE'(rx_data_i);

    // Frame assembly, bus sequencing, timeout and response serialisation.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            state_r          <= IDLE;
            code_r           <= 8'h00;
            status_r         <= 8'h00;
            opr_r            <= '0;
            cnt_r            <= '0;
            tmo_r            <= '0;
            tx_data_o        <= 8'h00;
            tx_valid_o       <= 1'b0;
            overflow_o       <= 1'b0;
            dbg.cmd          <= 8'h00;
            dbg.addr         <= '0;
            dbg.data_dbg_dut <= '0;
        end else begin
            if (rx_valid_i && (state_r != IDLE) && (state_r != RX_ADDR) &&
                (state_r != RX_DATA)) begin
                overflow_o <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (rx_valid_i && (rx_data_i != CMD_NOP)) begin
                        code_r <= rx_data_i;
                        cnt_r  <= '0;
                        tmo_r  <= '0;
                        if (!is_known(rx_data_i)) begin
                            status_r   <= ST_ERR;
                            tx_data_o  <= ST_ERR;
                            tx_valid_o <= 1'b1;
                            state_r    <= TX_STATUS;
                        end else if (has_addr(rx_data_i)) begin
                            state_r <= RX_ADDR;
                        end else if (dbg.dut_ready) begin
                            dbg.cmd <= rx_data_i;
                            state_r <= ISSUE;
                        end else begin
                            state_r <= WAIT_RDY;
                        end
                    end
                end
                RX_ADDR: begin
                    if (rx_valid_i) begin
                        opr_r <= opr_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_BYTE) begin
                            dbg.addr <= opr_next_s;
                            cnt_r    <= '0;
                            tmo_r    <= '0;
                            if (has_data(code_r)) begin
                                state_r <= RX_DATA;
                            end else if (dbg.dut_ready) begin
                                dbg.cmd <= code_r;
                                state_r <= ISSUE;
                            end else begin
                                state_r <= WAIT_RDY;
                            end
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_valid_i) begin
                        opr_r <= opr_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (cnt_r == LAST_BYTE) begin
                            dbg.data_dbg_dut <= opr_next_s;
                            cnt_r            <= '0;
                            tmo_r            <= '0;
                            if (dbg.dut_ready) begin
                                dbg.cmd <= code_r;
                                state_r <= ISSUE;
                            end else begin
                                state_r <= WAIT_RDY;
                            end
                        end
                    end
                end
                WAIT_RDY: begin
                    if (dbg.dut_ready) begin
                        dbg.cmd <= code_r;
                        tmo_r   <= '0;
                        state_r <= ISSUE;
                    end else if (tmo_r == TMO_LAST) begin
                        status_r <= ST_TIMEOUT;
                        state_r  <= RELEASE;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                ISSUE: begin
                    if (dbg.dut_done) begin
                        dbg.cmd  <= 8'h00;
                        opr_r    <= dbg.data_dut_dbg;
                        status_r <= ST_ACK;
                        state_r  <= RELEASE;
                    end else if (tmo_r == TMO_LAST) begin
                        dbg.cmd  <= 8'h00;
                        status_r <= ST_TIMEOUT;
                        state_r  <= RELEASE;
                    end else begin
                        tmo_r <= tmo_r + TMO_W'(1);
                    end
                end
                RELEASE: begin
                    if (!dbg.dut_done) begin
                        tx_data_o  <= status_r;
                        tx_valid_o <= 1'b1;
                        state_r    <= TX_STATUS;
                    end
                end
                TX_STATUS: begin
                    if (tx_ready_i) begin
                        if ((status_r == ST_ACK) && (code_r == CMD_READ)) begin
                            tx_data_o <= opr_r[BITSIZE-1 -: 8];
                            opr_r     <= opr_r << 8;
                            cnt_r     <= '0;
                            state_r   <= TX_DATA;
                        end else begin
                            tx_valid_o <= 1'b0;
                            state_r    <= IDLE;
                        end
                    end
                end
                TX_DATA: begin
                    if (tx_ready_i) begin
                        if (cnt_r == LAST_BYTE) begin
                            tx_valid_o <= 1'b0;
                            cnt_r      <= '0;
                            state_r    <= IDLE;
                        end else begin
                            tx_data_o <= opr_r[BITSIZE-1 -: 8];
                            opr_r     <= opr_r << 8;
                            cnt_r     <= cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    dbg.cmd    <= 8'h00;
                    tx_valid_o <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbg_cmd_ctrl.sv
// Directed bench for dbg_cmd_ctrl: host frames are driven byte by byte, the
// expected response bytes are queued when a frame is sent and compared as the
// transmitter accepts them.
module tb_dbg_cmd_ctrl;
    import dbg_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data_o;
    logic       tx_valid_o;
    logic       tx_ready;
    logic       overflow_o;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    logic       mon_pv = 1'b0;
    logic       mon_pr = 1'b0;
    logic [7:0] mon_pd = 8'h00;

    dbg_intf #(.BITSIZE(32)) bus ();

    dbg_cmd_ctrl #(.BITSIZE(32), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rstn_i     (rstn),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data_o),
        .tx_valid_o (tx_valid_o),
        .tx_ready_i (tx_ready),
        .overflow_o (overflow_o),
        .dbg        (bus.dbg)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) exp_q.push_back(w[8*i +: 8]);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 80 && (exp_q.size() != 0 || tx_valid_o); i++) tick();
        chk(tag, 64'({exp_q.size() == 0, tx_valid_o}), 64'(2'b10));
    endtask

    // Reset, then the directed scenarios in order.
    initial begin
        rstn     = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        tx_ready = 1'b1;
        bus.dut_ready    = 1'b1;
        bus.dut_done     = 1'b0;
        bus.data_dut_dbg = 32'h0;

        fork
            forever begin
                @(negedge clk);
                if (mon_pv && !mon_pr)
                    chk("tx_hold", 64'({tx_valid_o, tx_data_o}), 64'({1'b1, mon_pd}));
                if (tx_valid_o && tx_ready) begin
                    if (exp_q.size() == 0) chk("tx_unexpected", 64'(tx_data_o), 64'h100);
                    else chk("tx_byte", 64'(tx_data_o), 64'(exp_q.pop_front()));
                end
                mon_pv = tx_valid_o;
                mon_pr = tx_ready;
                mon_pd = tx_data_o;
            end
        join_none

        repeat (3) tick();
        chk("rst_state", 64'({bus.cmd, tx_valid_o, tx_data_o, overflow_o}), 64'h0);
        chk("rst_bus", 64'({bus.addr, bus.data_dbg_dut}), 64'h0);
        rstn = 1'b1;
        tick();

        // Write 0xDEADBEEF to 0x1000, done after 3 cycles.
        push_word({ST_ACK, 24'h0}); exp_q = exp_q[0:0];
        send_byte(CMD_WRITE);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        for (int i = 0; i < 3; i++) begin
            chk("wr_bus", 64'({bus.cmd, bus.addr, bus.data_dbg_dut} >> 8), 64'({CMD_WRITE, 32'h1000, 32'hDEADBEEF} >> 8));
            chk("wr_data", 64'(bus.data_dbg_dut), 64'hDEADBEEF);
            tick();
        end
        bus.dut_done = 1'b1;
        tick();
        chk("wr_cmd_drop", 64'({bus.cmd, tx_valid_o}), 64'h0);
        bus.dut_done = 1'b0;
        tick();
        chk("wr_tx_rise", 64'({tx_valid_o, tx_data_o}), 64'({1'b1, ST_ACK}));
        drain("wr_drain");

        // Read 0x4 returning 0x12345678 with a toggling transmitter.
        exp_q.push_back(ST_ACK); push_word(32'h12345678);
        send_byte(CMD_READ);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h04);
        chk("rd_bus", 64'({bus.cmd, bus.addr}), 64'({CMD_READ, 32'h4}));
        bus.dut_done = 1'b1;
        bus.data_dut_dbg = 32'h12345678;
        tick();
        chk("rd_cmd_drop", 64'(bus.cmd), 64'h0);
        bus.dut_done = 1'b0;
        bus.data_dut_dbg = 32'h0;
        tx_ready = 1'b0;
        for (int i = 0; i < 60 && (exp_q.size() != 0 || tx_valid_o); i++) begin
            tx_ready = ~tx_ready;
            tick();
        end
        tx_ready = 1'b1;
        drain("rd_drain");

        // Unknown command: error status next cycle, bus untouched.
        exp_q.push_back(ST_ERR);
        send_byte(8'h7F);
        chk("unk_resp", 64'({tx_valid_o, tx_data_o, bus.cmd}), 64'({1'b1, ST_ERR, 8'h00}));
        drain("unk_drain");
        chk("unk_cmd", 64'(bus.cmd), 64'h0);

        // HALT with late ready, then no done: timeout after 16 issue cycles.
        bus.dut_ready = 1'b0;
        exp_q.push_back(ST_TIMEOUT);
        send_byte(CMD_HALT);
        for (int i = 0; i < 5; i++) begin
            chk("halt_wait", 64'(bus.cmd), 64'h0);
            tick();
        end
        bus.dut_ready = 1'b1;
        chk("halt_pre", 64'(bus.cmd), 64'h0);
        tick();
        chk("halt_issue", 64'(bus.cmd), 64'(CMD_HALT));
        begin
            int n = 0;
            while (bus.cmd == CMD_HALT && n < 40) begin
                n++;
                tick();
            end
            chk("halt_tmo_len", 64'(n), 64'd16);
        end
        drain("halt_drain");

        // Byte injected during ISSUE sets sticky overflow; frame completes.
        chk("ovf_clear", 64'(overflow_o), 64'h0);
        exp_q.push_back(ST_ACK);
        send_byte(CMD_RESUME);
        chk("ovf_issue", 64'(bus.cmd), 64'(CMD_RESUME));
        send_byte(8'h55);
        chk("ovf_set", 64'({overflow_o, bus.cmd}), 64'({1'b1, CMD_RESUME}));
        bus.dut_done = 1'b1;
        tick();
        bus.dut_done = 1'b0;
        drain("ovf_drain");
        repeat (3) tick();
        chk("ovf_sticky", 64'({overflow_o, tx_valid_o}), 64'(2'b10));

        // Reset in the middle of a write frame, then a clean read.
        send_byte(CMD_WRITE);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        rstn = 1'b0;
        tick();
        chk("mid_rst", 64'({bus.cmd, tx_valid_o, tx_data_o, overflow_o}), 64'h0);
        chk("mid_rst_bus", 64'({bus.addr, bus.data_dbg_dut}), 64'h0);
        rstn = 1'b1;
        tick();
        exp_q.push_back(ST_ACK); push_word(32'hCAFEF00D);
        send_byte(CMD_READ);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h08);
        chk("post_rst_rd", 64'({bus.cmd, bus.addr}), 64'({CMD_READ, 32'h8}));
        bus.dut_done = 1'b1;
        bus.data_dut_dbg = 32'hCAFEF00D;
        tick();
        bus.dut_done = 1'b0;
        bus.data_dut_dbg = 32'h0;
        drain("post_rst_drain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbg_cmd_ctrl.md
# dbg_cmd_ctrl

Host-side command controller of the debug module. Assembles byte-serial host frames (from the UART receiver) into debug commands and drives them onto the `dbg` modport of `dbg_intf`. It waits for the DUT to complete each command, then serialises a status byte and any read data back to the UART transmitter.

## Interface
Parameters:
- `BITSIZE`, 32: address/data width; must equal the `dbg_intf` `BITSIZE` and be a multiple of 8.
- `TIMEOUT`, 1024: maximum cycles to wait for `dut_ready` or `dut_done` before aborting.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rstn_i`  in  1  reset; synchronous, active-low.
- `rx_data_i`  in  8  host byte.
- `rx_valid_i`  in  1  one-cycle strobe; `rx_data_i` is valid.
- `tx_data_o`  out  8  response byte.
- `tx_valid_o`  out  1  response byte valid; held until accepted.
- `tx_ready_i`  in  1  transmitter accepts the byte when `tx_valid_o && tx_ready_i`.
- `overflow_o`  out  1  sticky; a host byte was dropped. Cleared only by reset.
- `dbg`  `dbg_intf.dbg`  modport  drives `cmd`, `addr`, `data_dbg_dut`; samples `data_dut_dbg`, `dut_ready`, `dut_done`.

## Operation
Frame format:
- Byte 0: command.
- Then N = `BITSIZE/8` address bytes, MSB first, if the command takes an address.
- Then N data bytes, MSB first, if the command is a write.

Command codes:
- `CMD_READ` 0x01: address; returns data.
- `CMD_WRITE` 0x02: address + data.
- `CMD_HALT` 0x03, `CMD_RESUME` 0x04, `CMD_RESET` 0x05: no operands.
- `CMD_NOP` 0x00: ignored; no response.
- Any other code: not forwarded; respond `ST_ERR` 0xEE.

Response:
- Status byte: `ST_ACK` 0xAC, or `ST_TIMEOUT` 0xEF.
- After `ST_ACK` for `CMD_READ` only: N data bytes, MSB first.

FSM states:
- `IDLE`: wait for a command byte.
- `RX_ADDR`, `RX_DATA`: shift operand bytes into registers; a byte counter counts 0..N-1.
- `WAIT_RDY`: wait for `dut_ready`.
- `ISSUE`: `cmd`/`addr`/`data_dbg_dut` driven and held stable until `dut_done` is sampled high; `data_dut_dbg` is captured in that cycle.
- `RELEASE`: `cmd` = 0; wait for `dut_done` low.
- `TX_STATUS`, `TX_DATA`: send the response bytes.

Transitions:
- After `TX_DATA` (or `TX_STATUS` when no data follows), return to `IDLE`.
- Timeout: a counter runs in `WAIT_RDY` and `ISSUE` and reaching `TIMEOUT` → `cmd` = 0, go to `RELEASE`, and the status becomes 0xEF with no data bytes.
- `rx_valid_i` in any state other than `IDLE`/`RX_*` → byte dropped, `overflow_o` set.

Reset values: `cmd` = 0, `addr` = 0, `data_dbg_dut` = 0, `tx_valid_o` = 0, `tx_data_o` = 0, `overflow_o` = 0, state `IDLE`, all counters 0. A reset mid-operation abandons the frame with no response; `cmd` is 0 in the first cycle after reset.

## Timing
- The last operand byte (or the command byte, for no-operand commands) is accepted in cycle T.
- `cmd` is driven in T+1 if `dut_ready` was high in T; otherwise it is driven one cycle after `dut_ready` is first sampled high.
- If `dut_done` is sampled high in cycle D: `cmd` = 0 in D+1.
- `RELEASE` exits in the first cycle `dut_done` is sampled low; `tx_valid_o` rises in the next cycle.
- A `dut_done` that is already low in D+1 gives a minimum of 2 cycles from done to `tx_valid_o`.
- `tx_data_o` is stable while `tx_valid_o && !tx_ready_i`. The next byte is presented in the cycle after acceptance, so back-to-back bytes are 1 per cycle when `tx_ready_i` is held high.
- Unknown command: `tx_valid_o` with 0xEE in T+1; the DUT bus is untouched.
- A new frame is accepted only in `IDLE`, so bytes arriving during the response are overflow bytes.

## Structure
- Package `dbg_pkg`: `CMD_*` codes as `logic [7:0]` constants, `ST_*` codes, the FSM state enum, and the helper functions `has_addr(cmd)` and `has_data(cmd)`.
- The module instantiates no sub-modules. The operand shift register and byte counter are local.
- A natural split, not required: `dbg_tx_ser` as a parallel-to-byte serialiser for the response path.

## Test plan
- Write: bytes 02 00 00 10 00 DE AD BE EF, `dut_ready` = 1, `dut_done` after 3 cycles → `cmd` = 0x02, `addr` = 0x1000, `data_dbg_dut` = 0xDEADBEEF, all stable until done; response AC.
- Read: bytes 01 00 00 00 04, DUT returns 0x12345678 with done → response AC 12 34 56 78; with `tx_ready_i` toggling every other cycle, the bytes are unchanged and in order.
- Unknown 0x7F → response EE within 1 cycle; `cmd` never leaves 0.
- HALT with `dut_ready` low 5 cycles → `cmd` asserted exactly 1 cycle after `dut_ready` rises. DUT never asserts done with `TIMEOUT` = 16 → `cmd` drops after 16 cycles; response EF.
- Byte injected during `ISSUE` → `overflow_o` = 1 and stays set; the frame in flight completes normally.
- `rstn_i` low during `RX_DATA` after 2 data bytes → outputs at reset values. A fresh READ frame then completes correctly, showing no stale byte count.
